// File: rtl/phv_action_align.sv
// phv_action_align: holds each PHV in an in-order FIFO until its lookup action
// returns, then presents the PHV/action pair to the crossbar on one registered cycle.
module phv_action_align #(
  parameter int PHV_LEN = 1124,
  parameter int ACT_LEN = 25,
  parameter int ACT_NUM = 25,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PHV_LEN-1:0]         phv_in,
  input  logic                       phv_in_valid,
  input  logic [ACT_LEN*ACT_NUM-1:0] action_in,
  input  logic                       action_in_valid,
  output logic [PHV_LEN-1:0]         phv_out,
  output logic                       phv_out_valid,
  output logic [ACT_LEN*ACT_NUM-1:0] action_out,
  output logic                       action_out_valid,
  output logic                       stall_out,
  output logic [ADDR_W:0]            occupancy,
  output logic                       overflow_err,
  output logic                       orphan_err,
  output logic [15:0]                drop_cnt
);

  localparam int ACT_W = ACT_LEN * ACT_NUM;
  localparam logic [ADDR_W:0]   ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   STALL_C = (ADDR_W+1)'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] PINC_C  = ADDR_W'(1);

  logic [PHV_LEN-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    occ_q, occ_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic [ACT_W-1:0]   act_out_q, act_out_d;
  logic               out_vld_q, out_vld_d;
  logic               stall_q, stall_d;
  logic               ovf_q, ovf_d;
  logic               orph_q, orph_d;
  logic [15:0]        drop_q, drop_d;
  logic               pop_s, push_s, drop_s;

  // Push/pop decode and next-state for pointers, occupancy, outputs and error state.
  always_comb begin
    pop_s     = 1'b0;
    push_s    = 1'b0;
    drop_s    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    phv_out_d = phv_out_q;
    act_out_d = act_out_q;
    out_vld_d = 1'b0;
    ovf_d     = ovf_q;
    orph_d    = orph_q;
    drop_d    = drop_q;

    // A same-cycle pop frees a slot, so a full FIFO still accepts a PHV.
    pop_s  = action_in_valid && (occ_q != ZERO_C);
    push_s = phv_in_valid && ((occ_q != FULL_C) || pop_s);
    drop_s = phv_in_valid && !push_s;

    if (pop_s) begin
      phv_out_d = mem_q[rd_ptr_q];
      act_out_d = action_in;
      out_vld_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PINC_C;
    end else begin
      out_vld_d = 1'b0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PINC_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + ONE_C;
      2'b01:   occ_d = occ_q - ONE_C;
      default: occ_d = occ_q;
    endcase

    if (action_in_valid && !pop_s) begin
      orph_d = 1'b1;
    end else begin
      orph_d = orph_q;
    end

    if (drop_s) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 16'hFFFF) ? drop_q : (drop_q + 16'd1);
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end

    stall_d = (occ_d >= STALL_C);
  end

  // Control and output registers; reset wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {ADDR_W{1'b0}};
      rd_ptr_q  <= {ADDR_W{1'b0}};
      occ_q     <= ZERO_C;
      phv_out_q <= {PHV_LEN{1'b0}};
      act_out_q <= {ACT_W{1'b0}};
      out_vld_q <= 1'b0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      orph_q    <= 1'b0;
      drop_q    <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      phv_out_q <= phv_out_d;
      act_out_q <= act_out_d;
      out_vld_q <= out_vld_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
      orph_q    <= orph_d;
      drop_q    <= drop_d;
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= phv_in;
    end
  end

  assign phv_out          = phv_out_q;
  assign phv_out_valid    = out_vld_q;
  assign action_out       = act_out_q;
  assign action_out_valid = out_vld_q;
  assign stall_out        = stall_q;
  assign occupancy        = occ_q;
  assign overflow_err     = ovf_q;
  assign orphan_err       = orph_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_phv_action_align.sv
// Directed bench for phv_action_align: tagged PHVs and actions with
// hand-computed pairing, occupancy and error expectations.
module tb_phv_action_align;
  localparam int W     = 1124;
  localparam int ACT_W = 625;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     phv_in;
  logic             phv_in_valid;
  logic [ACT_W-1:0] action_in;
  logic             action_in_valid;
  logic [W-1:0]     phv_out;
  logic             phv_out_valid;
  logic [ACT_W-1:0] action_out;
  logic             action_out_valid;
  logic             stall_out;
  logic [3:0]       occupancy;
  logic             overflow_err;
  logic             orphan_err;
  logic [15:0]      drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  phv_action_align dut (
    .clk(clk), .rst(rst),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .action_in(action_in), .action_in_valid(action_in_valid),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .action_out(action_out), .action_out_valid(action_out_valid),
    .stall_out(stall_out), .occupancy(occupancy),
    .overflow_err(overflow_err), .orphan_err(orphan_err),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [W-1:0] mk_phv(input logic [7:0] t);
    logic [W-1:0] v;
    v = '0;
    v[7:0]       = t;
    v[600 +: 8]  = t ^ 8'h5A;
    v[W-1 -: 8]  = ~t;
    return v;
  endfunction

  function automatic logic [ACT_W-1:0] mk_act(input logic [7:0] t);
    logic [ACT_W-1:0] v;
    v = '0;
    v[7:0]          = t;
    v[ACT_W-1 -: 8] = ~t;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed lo=%h hi=%h expected lo=%h hi=%h",
             tag, obs[31:0], obs[W-1 -: 32], exp[31:0], exp[W-1 -: 32]);
    end
  endtask

  task automatic cyc(input logic pv, input logic [7:0] pt, input logic av, input logic [7:0] at);
    phv_in_valid    = pv;
    phv_in          = pv ? mk_phv(pt) : '0;
    action_in_valid = av;
    action_in       = av ? mk_act(at) : '0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input logic [7:0] pt, input logic [7:0] at);
    chk("phv_valid", W'(phv_out_valid), W'(1'b1));
    chk("act_valid", W'(action_out_valid), W'(1'b1));
    chk("phv_out", phv_out, mk_phv(pt));
    chk("action_out", W'(action_out), W'(mk_act(at)));
  endtask

  task automatic chk_none();
    chk("phv_valid_idle", W'(phv_out_valid), W'(1'b0));
    chk("act_valid_idle", W'(action_out_valid), W'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    chk_none();
    chk("rst_phv_out", phv_out, '0);
    chk("rst_act_out", W'(action_out), '0);
    chk("rst_occ", W'(occupancy), W'(0));
    chk("rst_stall", W'(stall_out), W'(1'b0));
    chk("rst_ovf", W'(overflow_err), W'(1'b0));
    chk("rst_orph", W'(orphan_err), W'(1'b0));
    chk("rst_drop", W'(drop_cnt), W'(0));

    // Lookup latency 3
    cyc(1'b1, 8'h01, 1'b0, 8'h00);
    chk_none();
    cyc(1'b1, 8'h02, 1'b0, 8'h00);
    cyc(1'b1, 8'h03, 1'b0, 8'h00);
    chk("l3_occ_peak", W'(occupancy), W'(3));
    cyc(1'b1, 8'h04, 1'b1, 8'h41);
    chk_out(8'h01, 8'h41);
    chk("l3_occ_pp", W'(occupancy), W'(3));
    cyc(1'b0, 8'h00, 1'b1, 8'h42);
    chk_out(8'h02, 8'h42);
    cyc(1'b0, 8'h00, 1'b1, 8'h43);
    chk_out(8'h03, 8'h43);
    cyc(1'b0, 8'h00, 1'b1, 8'h44);
    chk_out(8'h04, 8'h44);
    chk("l3_occ_end", W'(occupancy), W'(0));
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    chk_none();
    chk("hold_phv", phv_out, mk_phv(8'h04));
    chk("hold_act", W'(action_out), W'(mk_act(8'h44)));
    chk("l3_ovf", W'(overflow_err), W'(1'b0));
    chk("l3_orph", W'(orphan_err), W'(1'b0));

    // Overflow: 10 PHVs into 8 entries
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 8'(k), 1'b0, 8'h00);
      chk("ovf_occ", W'(occupancy), W'((k > 8) ? 8 : k));
      chk("ovf_stall", W'(stall_out), W'(k >= 6));
      chk("ovf_err", W'(overflow_err), W'(k > 8));
      chk("ovf_drop", W'(drop_cnt), W'((k > 8) ? (k - 8) : 0));
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 8'(8'h80 + k));
      chk_out(8'(k), 8'(8'h80 + k));
      chk("drain_occ", W'(occupancy), W'(8 - k));
      chk("drain_stall", W'(stall_out), W'(k <= 2));
    end

    // Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 8; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0, 8'h00);
    chk("full_occ", W'(occupancy), W'(8));
    cyc(1'b1, 8'h20, 1'b1, 8'h90);
    chk_out(8'h11, 8'h90);
    chk("fpp_occ", W'(occupancy), W'(8));
    chk("fpp_drop", W'(drop_cnt), W'(2));
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 8'(8'hA0 + k));
      chk_out((k < 7) ? 8'(8'h12 + k) : 8'h20, 8'(8'hA0 + k));
    end
    chk("fpp_occ_end", W'(occupancy), W'(0));

    // Orphan action, then same-cycle PHV+action on empty FIFO
    cyc(1'b0, 8'h00, 1'b1, 8'h99);
    chk_none();
    chk("orph_err", W'(orphan_err), W'(1'b1));
    chk("orph_occ", W'(occupancy), W'(0));
    cyc(1'b1, 8'h30, 1'b1, 8'h9A);
    chk_none();
    chk("same_cyc_occ", W'(occupancy), W'(1));
    cyc(1'b0, 8'h00, 1'b1, 8'h9B);
    chk_out(8'h30, 8'h9B);
    chk("orph_occ_end", W'(occupancy), W'(0));
    chk("ovf_sticky", W'(overflow_err), W'(1'b1));

    // Pointer wrap: 20 pairs at latency 1
    cyc(1'b1, 8'h40, 1'b0, 8'h00);
    chk("wrap_occ0", W'(occupancy), W'(1));
    for (int k = 1; k < 20; k++) begin
      cyc(1'b1, 8'(8'h40 + k), 1'b1, 8'(8'hB0 + k - 1));
      chk_out(8'(8'h40 + k - 1), 8'(8'hB0 + k - 1));
      chk("wrap_occ", W'(occupancy), W'(1));
    end
    cyc(1'b0, 8'h00, 1'b1, 8'hC3);
    chk_out(8'h53, 8'hC3);
    chk("wrap_occ_end", W'(occupancy), W'(0));

    // Reset mid-operation, with a push and action asserted during reset
    for (int k = 1; k <= 5; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0, 8'h00);
    chk("pre_rst_occ", W'(occupancy), W'(5));
    rst = 1'b1;
    cyc(1'b1, 8'h70, 1'b1, 8'hD0);
    rst = 1'b0;
    chk_none();
    chk("mrst_phv_out", phv_out, '0);
    chk("mrst_occ", W'(occupancy), W'(0));
    chk("mrst_ovf", W'(overflow_err), W'(1'b0));
    chk("mrst_orph", W'(orphan_err), W'(1'b0));
    chk("mrst_drop", W'(drop_cnt), W'(0));
    chk("mrst_stall", W'(stall_out), W'(1'b0));
    cyc(1'b0, 8'h00, 1'b1, 8'hD1);
    chk_none();
    chk("mrst_orph_after", W'(orphan_err), W'(1'b1));
    chk("mrst_occ_after", W'(occupancy), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/phv_action_align.md
Name: phv_action_align

Overview:
- Sits directly upstream of the per-stage crossbar, between the key extractor/lookup engine and the crossbar.
- Each PHV enters the lookup at the same time it enters this block. The block buffers the PHV in an in-order FIFO.
- When the lookup returns the matching action vector, the block presents the PHV and action together on one cycle. This guarantees the crossbar always samples matched phv_in/action_in pairs.
- Lookup results return strictly in PHV order with latency of at least 1 cycle.

Parameters:
- PHV_LEN, 1124, PHV width (8x6B + 8x4B + 8x2B + 5x20 metadata + 256).
- ACT_LEN, 25, width of one container action.
- ACT_NUM, 25, number of container actions per action vector.
- DEPTH, 8, PHV FIFO entries (power of two).
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous, active-high reset.
- phv_in  in  PHV_LEN  PHV from the parser/previous stage.
- phv_in_valid  in  1  PHV strobe, one cycle per PHV.
- action_in  in  ACT_LEN*ACT_NUM  action vector from lookup.
- action_in_valid  in  1  action strobe, one cycle per action vector.
- phv_out  out  PHV_LEN  PHV to the crossbar.
- phv_out_valid  out  1  PHV strobe to the crossbar.
- action_out  out  ACT_LEN*ACT_NUM  action to the crossbar.
- action_out_valid  out  1  action strobe; always equal to phv_out_valid.
- stall_out  out  1  back-pressure to upstream: occupancy >= DEPTH-2.
- occupancy  out  ADDR_W+1  current FIFO entry count.
- overflow_err  out  1  sticky: a PHV was dropped because the FIFO was full.
- orphan_err  out  1  sticky: an action arrived with no buffered PHV.
- drop_cnt  out  16  number of PHVs dropped on overflow; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr, rd_ptr and occupancy go to 0.
  - phv_out_valid, action_out_valid, overflow_err and orphan_err go to 0.
  - phv_out and action_out go to all-zero; drop_cnt goes to 0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all buffered PHVs; no output strobe occurs in the cycle after reset.
- Pop:
  - pop = action_in_valid && (occupancy != 0), where occupancy is the registered value at the start of the cycle.
  - On pop, the next clk edge registers phv_out <= fifo[rd_ptr] and action_out <= action_in, sets both valids to 1, and advances rd_ptr (mod DEPTH).
  - Latency from action_in_valid to output valid is exactly 1 cycle.
  - Without a pop, both valids are 0 on the next cycle; phv_out and action_out hold their last values.
- Orphan action: action_in_valid with occupancy==0 is discarded, orphan_err <= 1, and no output strobe is produced.
- A PHV arriving in the same cycle never pairs with a same-cycle action; that action pops the oldest buffered entry or is treated as an orphan.
- Push:
  - push = phv_in_valid && ((occupancy != DEPTH) || pop). A pop in the same cycle frees a slot, so a full FIFO accepts a PHV when popped in the same cycle.
  - On push, fifo[wr_ptr] <= phv_in and wr_ptr advances (mod DEPTH).
- Overflow: phv_in_valid && !push drops the PHV, sets overflow_err <= 1 and increments drop_cnt (saturating).
- Occupancy update:
  - push && !pop: +1.
  - pop && !push: -1.
  - Both or neither: unchanged.
  - occupancy never exceeds DEPTH and never underflows.
- stall_out is decoded from registered occupancy with no combinational path from the inputs.
- Pointer wrap: pointers are ADDR_W bits and wrap naturally. Full/empty are determined solely by occupancy.
- Sticky errors clear only on rst.
- Pairing is always FIFO order: the k-th accepted PHV pairs with the k-th non-orphan action.

Test Plan:
- Lookup latency 3: 4 PHVs tagged 0x1..0x4 on consecutive cycles, 4 actions starting 3 cycles later -> output pairs in order 0x1..0x4, each 1 cycle after its action; occupancy peaks at 3; no errors.
- Overflow: 10 PHVs with no actions, DEPTH=8 -> occupancy=8, stall_out=1 from occupancy 6, overflow_err=1, drop_cnt=2. Then 8 actions -> tags 1..8 out, occupancy returns to 0.
- Full plus simultaneous push/pop: with occupancy=8, drive phv_in_valid and action_in_valid in the same cycle -> PHV accepted, oldest PHV output, occupancy stays 8, drop_cnt unchanged.
- Orphan: action_in_valid with the FIFO empty -> no output strobe, orphan_err=1. A subsequent PHV/action pair still aligns correctly.
- Pointer wrap: 20 PHV/action pairs at latency 1 -> all 20 tags out in order across the pointer wraps, occupancy never exceeds 1.
- Reset mid-operation: 5 PHVs buffered, rst for 1 cycle, then 1 action -> orphan_err=1 and no output. occupancy, errors and drop_cnt read 0 immediately after reset.
